// File: rtl/accel_mmio_bridge.sv
// accel_mmio_bridge: picoRV32 MMIO slave that loads the NN image, runs the accelerator and reports the argmax class
module accel_mmio_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int NUM_PIX = 785,
  parameter int NUM_CLASSES = 10,
  parameter int START_CYCLES = 2,
  parameter int GUARD_CYCLES = 4,
  parameter int TIMEOUT = 200000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wstrb,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic [NUM_PIX*32-1:0]    acc_image,
  output logic                     acc_start,
  input  logic                     acc_ready,
  input  logic [NUM_CLASSES*32-1:0] acc_result,
  output logic                     irq_done
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int IW = $clog2(NUM_PIX * 32);
  typedef enum logic [2:0] {IDLE, START, GUARD, WAIT, CAPTURE, ARGMAX, DONE} state_t;
  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [3:0] k, best, argmax;
  logic signed [31:0] res [NUM_CLASSES];
  logic [NUM_PIX*32-1:0] img;
  logic done, timeout, wr_err, pend_start;
  logic [10:0] idx;
  logic [IW-1:0] base;
  logic acc, wr, busy, is_img, timed_out, unused_ok;
  logic [31:0] rd_val;
  assign idx = mem_addr[12:2];
  assign base = {idx[IW-6:0], 5'd0};
  assign acc = mem_valid && mem_addr[31:13] == BASE_ADDR[31:13] && !mem_ready;
  assign wr = acc && |mem_wstrb;
  assign busy = state != IDLE;
  assign is_img = idx < 11'(NUM_PIX);
  assign acc_image = img;
  assign acc_start = state == START;
  assign irq_done = state == DONE;
  assign timed_out = state == WAIT && !acc_ready && cnt == CW'(TIMEOUT - 1);
  assign unused_ok = ^mem_addr[1:0];
  assign rd_val = is_img ? img[base +: 32] :
                  idx == 11'h401 ? {28'd0, wr_err, timeout, done, busy} :
                  idx == 11'h402 ? {28'd0, argmax} :
                  (idx >= 11'h404 && idx < 11'h404 + 11'(NUM_CLASSES)) ? res[4'(idx - 11'h404)] : '0;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = pend_start ? START : IDLE;
      START:   state_next = cnt == CW'(START_CYCLES - 1) ? GUARD : START;
      GUARD:   state_next = cnt == CW'(GUARD_CYCLES - 1) ? WAIT : GUARD;
      WAIT:    state_next = acc_ready ? CAPTURE : timed_out ? IDLE : WAIT;
      CAPTURE: state_next = ARGMAX;
      ARGMAX:  state_next = k == 4'(NUM_CLASSES - 1) ? DONE : ARGMAX;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      k <= '0;
      best <= '0;
      argmax <= '0;
      img <= '0;
      {done, timeout, wr_err, pend_start} <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) res[i] <= '0;
    end else begin
      mem_ready <= acc;
      mem_rdata <= acc ? rd_val : '0;
      pend_start <= wr && idx == 11'h400 && mem_wdata[0] && !busy;
      cnt <= state_next != state ? '0 : cnt + 1'b1;
      if (wr && is_img) begin
        if (busy) wr_err <= 1'b1;
        else for (int b = 0; b < 4; b++) if (mem_wstrb[b]) img[base + IW'(8 * b) +: 8] <= mem_wdata[8 * b +: 8];
      end
      if (state == IDLE && pend_start) {done, timeout, wr_err} <= '0;
      if (timed_out) timeout <= 1'b1;
      if (state == CAPTURE) begin
        for (int i = 0; i < NUM_CLASSES; i++) res[i] <= acc_result[32 * i +: 32];
        best <= '0;
        k <= 4'd1;
      end
      if (state == ARGMAX) begin
        if (res[k] > res[best]) best <= k;
        k <= k + 1'b1;
      end
      if (state == DONE) begin
        argmax <= best;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_accel_mmio_bridge.sv
// tb_accel_mmio_bridge: directed/randomized bench with a word-level model of image, scores and argmax
module tb_accel_mmio_bridge;
  localparam int NP = 785, NC = 10, TO = 40;
  localparam logic [31:0] B = 32'h0200_0000;
  logic clk = 0, resetn = 0, mem_valid = 0, acc_ready = 0;
  logic mem_ready, acc_start, irq_done;
  logic [31:0] mem_addr = 0, mem_wdata = 0, mem_rdata;
  logic [3:0] mem_wstrb = 0;
  logic [NP*32-1:0] acc_image;
  logic [NC*32-1:0] acc_result = '0;
  int n_cmp = 0, n_err = 0, cyc = 0, irq_cnt = 0, irq_cyc = 0, start_cnt = 0;
  logic [31:0] img_m [NP];
  logic [31:0] res_m [NC];
  logic [3:0] am_m = 0;
  int sc [NC];

  accel_mmio_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .acc_image(acc_image), .acc_start(acc_start), .acc_ready(acc_ready),
    .acc_result(acc_result), .irq_done(irq_done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (irq_done) begin irq_cnt++; irq_cyc = cyc; end
    if (acc_start) start_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r, output int ack);
    int n = 0;
    @(negedge clk);
    while (mem_ready) @(negedge clk);
    mem_valid = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    do begin @(posedge clk); #1; n++; end while (!mem_ready && n < 10);
    chk("ack_latency", 32'(n), 32'd1);
    r = mem_rdata; ack = cyc;
    mem_valid = 0; mem_wstrb = 0;
  endtask

  task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] r; int a;
    bus(B + off, 32'd0, 4'd0, r, a);
    chk(tag, r, exp);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r; int a;
    bus(B + off, d, s, r, a);
  endtask

  task automatic go(output int ack);
    logic [31:0] r;
    bus(B + 32'h1000, 32'h1, 4'hf, r, ack);
  endtask

  task automatic wait_irq(input int base, input int lim, output bit got);
    int n = 0;
    while (irq_cnt == base && n < lim) begin @(posedge clk); #1; n++; end
    got = irq_cnt != base;
  endtask

  function automatic void mwr(input int i, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) img_m[i][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic logic [3:0] ref_am();
    int mx = sc[0], r = 0;
    foreach (sc[j]) if (sc[j] > mx) mx = sc[j];
    for (int j = NC - 1; j >= 0; j--) if (sc[j] == mx) r = j;
    return 4'(r);
  endfunction

  task automatic load_scores();
    for (int j = 0; j < NC; j++) acc_result[32*j +: 32] = sc[j];
  endtask

  task automatic capture_model();
    for (int j = 0; j < NC; j++) res_m[j] = sc[j];
    am_m = ref_am();
  endtask

  task automatic check_results(input string tag);
    for (int j = 0; j < NC; j++) rd($sformatf("%s_res%0d", tag, j), 32'h1010 + 32'(4 * j), res_m[j]);
    rd({tag, "_argmax"}, 32'h1008, {28'd0, am_m});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack, bi, bs, w0, j, idx;
    bit got, seen;
    logic [31:0] d, r;
    logic [3:0] s;
    foreach (img_m[i]) img_m[i] = '0;
    foreach (res_m[i]) res_m[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_acc_start", 32'(acc_start), 0);
    chk("rst_irq", 32'(irq_done), 0);
    chk("rst_mem_ready", 32'(mem_ready), 0);
    @(negedge clk) resetn = 1;
    rd("rst_status", 32'h1004, 0);
    rd("rst_argmax", 32'h1008, 0);
    rd("rst_res0", 32'h1010, 0);
    rd("rst_img0", 32'h0000, 0);
    @(posedge clk); #1;
    chk("rdata_idle_zero", mem_rdata, 0);
    chk("ready_one_cycle", 32'(mem_ready), 0);
    @(negedge clk);
    mem_valid = 1; mem_addr = 32'h0200_2000; mem_wstrb = 4'hf; seen = 0;
    repeat (4) begin @(posedge clk); #1; seen |= mem_ready; end
    mem_valid = 0; mem_wstrb = 0;
    chk("out_of_window_ready", 32'(seen), 0);
    wr(32'h0C44, 32'h1234_5678, 4'hf);
    rd("unmapped_c44", 32'h0C44, 0);
    rd("ctrl_reads_zero", 32'h1000, 0);
    rd("unmapped_100c", 32'h100C, 0);

    wr(32'h0C40, 32'hDEAD_BEEF, 4'b0011);
    mwr(784, 32'hDEAD_BEEF, 4'b0011);
    rd("img784_strobe", 32'h0C40, img_m[784]);
    chk("acc_image_784", acc_image[25119:25088], img_m[784]);
    for (int i = 0; i < NP - 1; i++) begin
      d = $urandom; s = 4'($urandom_range(1, 15));
      wr(32'(4 * i), d, s);
      mwr(i, d, s);
    end
    repeat (16) begin
      idx = $urandom_range(0, NP - 1);
      rd($sformatf("img_rd%0d", idx), 32'(4 * idx), img_m[idx]);
    end
    for (int i = 0; i < NP; i++) chk($sformatf("acc_image%0d", i), acc_image[32*i +: 32], img_m[i]);

    sc = '{5, -3, 9, 9, 0, 0, 0, 0, 0, 0};
    load_scores();
    acc_ready = 1;
    bi = irq_cnt; bs = start_cnt;
    go(ack);
    wait_irq(bi, 100, got);
    chk("run1_irq", 32'(got), 1);
    chk("run1_latency", 32'(irq_cyc - ack), 32'd18);
    chk("run1_start_cycles", 32'(start_cnt - bs), 32'd2);
    capture_model();
    rd("run1_status", 32'h1004, 32'b0010);
    check_results("run1");
    chk("run1_irq_count", 32'(irq_cnt - bi), 1);

    foreach (sc[i]) sc[i] = -int'($urandom_range(1, 1000));
    sc[0] = -1;
    j = $urandom_range(1, 8);
    sc[j] = 0;
    sc[$urandom_range(j, 9)] = 0;
    load_scores();
    acc_ready = 0;
    w0 = $urandom_range(0, 20);
    bi = irq_cnt;
    go(ack);
    @(posedge clk); #1;
    acc_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    acc_ready = 0;
    repeat (w0) @(posedge clk);
    #1;
    acc_ready = 1;
    wait_irq(bi, 100, got);
    chk("run2_irq", 32'(got), 1);
    chk("run2_latency", 32'(irq_cyc - ack), 32'(18 + w0));
    capture_model();
    check_results("run2");

    foreach (sc[i]) sc[i] = int'($urandom);
    load_scores();
    acc_ready = 0;
    bi = irq_cnt; bs = start_cnt;
    go(ack);
    idx = $urandom_range(0, NP - 1);
    wr(32'(4 * idx), ~img_m[idx], 4'hf);
    wr(32'h1000, 32'h1, 4'hf);
    rd("busy_status", 32'h1004, 32'b1001);
    acc_ready = 1;
    wait_irq(bi, 200, got);
    chk("run3_irq", 32'(got), 1);
    chk("run3_start_cycles", 32'(start_cnt - bs), 32'd2);
    capture_model();
    rd("run3_status", 32'h1004, 32'b1010);
    rd("run3_img_kept", 32'(4 * idx), img_m[idx]);
    chk("run3_acc_image_kept", acc_image[32*idx +: 32], img_m[idx]);
    check_results("run3");

    foreach (sc[i]) sc[i] = int'($urandom);
    load_scores();
    acc_ready = 0;
    bi = irq_cnt;
    go(ack);
    rd("to_status_busy", 32'h1004, 32'b0001);
    repeat (TO + 20) @(posedge clk);
    #1;
    chk("to_no_irq", 32'(irq_cnt - bi), 0);
    rd("to_status", 32'h1004, 32'b0100);
    check_results("to");

    bi = irq_cnt;
    go(ack);
    repeat (15) @(posedge clk);
    #2;
    resetn = 0;
    #1;
    chk("mid_rst_acc_start", 32'(acc_start), 0);
    chk("mid_rst_irq", 32'(irq_done), 0);
    chk("mid_rst_mem_ready", 32'(mem_ready), 0);
    chk("mid_rst_rdata", mem_rdata, 0);
    chk("mid_rst_image", 32'(|acc_image), 0);
    foreach (img_m[i]) img_m[i] = '0;
    foreach (res_m[i]) res_m[i] = '0;
    am_m = 0;
    @(negedge clk) resetn = 1;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_rst_no_irq", 32'(irq_cnt - bi), 0);
    rd("post_rst_status", 32'h1004, 0);
    rd("post_rst_img784", 32'h0C40, img_m[784]);
    check_results("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/accel_mmio_bridge.md
Name: accel_mmio_bridge

Overview:
- CPU-side counterpart of the NN accelerator: a picoRV32 native-bus slave that assembles the 785-word image from 32-bit CPU writes and launches the accelerator.
- Waits for the accelerator's ready, captures the ten class scores, and computes the argmax sequentially.
- Exposes status, results and argmax as memory-mapped registers, plus a one-cycle done interrupt.

Parameters:
- BASE_ADDR, 32'h0200_0000, base of the 8 KB decode window (BASE_ADDR[12:0] must be 0)
- NUM_PIX, 785, image words, including the bias word
- NUM_CLASSES, 10, result words
- START_CYCLES, 2, cycles acc_start is held high
- GUARD_CYCLES, 4, cycles after acc_start falls during which acc_ready is ignored
- TIMEOUT, 200000, maximum wait cycles for acc_ready

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  picoRV32 request valid
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; 0 = read
- mem_ready  out  1  one-cycle acknowledge
- mem_rdata  out  32  read data, valid while mem_ready=1
- acc_image  out  NUM_PIX*32  image buffer; word i at [32i+31:32i]
- acc_start  out  1  drives the accelerator's active-high reset/invoke input
- acc_ready  in  1  accelerator ready
- acc_result  in  NUM_CLASSES*32  scores; class k at [32k+31:32k]
- irq_done  out  1  one-cycle pulse on completion

Behaviour:
- Reset (resetn=0, asynchronous): image buffer, result registers, argmax, status bits, mem_ready, mem_rdata, acc_start and irq_done all go to 0; FSM enters IDLE.
  - Reset mid-run aborts the run with no irq_done.
- Decode: sel = mem_valid & (mem_addr[31:13] == BASE_ADDR[31:13]). Offset = mem_addr[12:0]; mem_addr[1:0] is ignored.
- Handshake:
  - On sel with mem_ready=0, the block registers the access and asserts mem_ready for exactly one cycle on the next edge. mem_rdata is valid in that cycle and is 0 otherwise.
  - Back-to-back requests therefore complete every 2 cycles.
  - When sel=0, mem_ready stays 0.
- Register map (offsets):
  - 0x000-0xC40, IMAGE[i] at 4i: read/write, per-byte wstrb honoured.
    - Writes while busy are acknowledged but discarded, and set wr_err.
  - 0x1000, CTRL: write with wdata[0]=1 starts a run if idle; ignored if busy. Reads return 0.
  - 0x1004, STATUS (read-only): bit0 busy, bit1 done, bit2 timeout, bit3 wr_err.
    - A start clears done, timeout and wr_err.
  - 0x1008, ARGMAX (read-only): bits[3:0] = class index, upper bits 0.
  - 0x1010+4k, RESULT[k], k=0..9 (read-only): captured scores.
  - All other in-window offsets: acknowledged, writes ignored, reads return 0.
- FSM states:
  - IDLE: busy=0. An accepted start (in its mem_ready cycle) moves to START.
  - START: acc_start=1 for START_CYCLES cycles, then GUARD.
  - GUARD: GUARD_CYCLES cycles with acc_ready ignored, then WAIT.
  - WAIT: acc_ready=1 moves to CAPTURE. The wait counter counts cycles spent in WAIT; when it reaches TIMEOUT, the FSM sets timeout and returns to IDLE, and RESULT/ARGMAX keep their old values.
  - CAPTURE: latch all acc_result words into RESULT (1 cycle), set best=0, k=1, then ARGMAX.
  - ARGMAX: one compare per cycle, k=1..NUM_CLASSES-1. Comparison is signed 32-bit; the index is replaced only on strictly greater, so ties keep the lowest index. After k=9, go to DONE.
  - DONE: write ARGMAX, set done, pulse irq_done for 1 cycle, return to IDLE.
- busy=1 in every state except IDLE.
- Latency from start acknowledge to irq_done: START_CYCLES + GUARD_CYCLES + W + 1 + 9 + 1 cycles, where W = number of WAIT cycles.
- acc_image is driven continuously from the buffer and is stable throughout a run, because buffer writes are blocked while busy.
- An acc_ready glitch during START or GUARD has no effect.

Test Plan:
- Reset, then read STATUS, ARGMAX, RESULT0 and IMAGE[0] -> all 0; mem_ready asserts exactly 1 cycle after mem_valid.
- Write IMAGE[784]=32'hDEADBEEF with wstrb=4'b0011, then read it back -> 32'h0000BEEF; acc_image[25119:25088] matches.
- Start with acc_ready held at 1 throughout -> acc_start high 2 cycles; capture happens only after the 4 guard cycles; irq_done pulses at the computed latency.
- Scores {5,-3,9,9,0,...,0} -> ARGMAX=2 (tie keeps the lower index); a score of -1 is never chosen over 0.
- acc_ready never asserted -> STATUS=0b100 after TIMEOUT wait cycles; previous RESULT values unchanged; no irq_done.
- During busy: image write and second start -> wr_err set, buffer unchanged, run unaffected. Deassert resetn mid-WAIT -> all outputs 0 immediately, acc_start low.
